// File: rtl/md_ctrl_if.sv
// Issue/result bundle between the Execute-stage issue logic, the hazard unit
// and the multiply/divide sequencer.
interface md_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        md_in_D;
  logic        busy;
  logic        stall_req;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, op, A, B, md_in_D,
    input  busy, stall_req, HI, LO
  );

  modport slave (
    input  start, op, A, B, md_in_D,
    output busy, stall_req, HI, LO
  );
endinterface

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, models multi-cycle latency with a
// down-counter and commits a precomputed result when the counter expires.
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  md_ctrl_if.slave  md
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [31:0]   phi_r;
  logic [31:0]   plo_r;
  logic [31:0]   hi_r;
  logic [31:0]   lo_r;
  logic          busy_r;

  // Full {HI,LO} result of a mult/multu/div/divu; other ops yield zero.
  function automatic logic [63:0] md_result(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa64;
    logic signed [63:0] sb64;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    logic [63:0]        r;
    sa64 = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    sq   = 32'sd0;
    sr   = 32'sd0;
    r    = 64'd0;
    case (op)
      3'd0: r = sa64 * sb64;
      3'd1: r = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) begin
          r = {a, 32'hFFFF_FFFF};
        end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
          // Quotient overflows; result wraps to the dividend with zero remainder.
          r = {32'd0, 32'h8000_0000};
        end else begin
          sq = $signed(a) / $signed(b);
          sr = $signed(a) % $signed(b);
          r  = {sr, sq};
        end
      end
      3'd3: begin
        if (b == 32'd0) begin
          r = {a, 32'hFFFF_FFFF};
        end else begin
          r = {a % b, a / b};
        end
      end
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  // Sequencer state, pending result and architectural HI/LO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      phi_r   <= 32'd0;
      plo_r   <= 32'd0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (md.start) begin
            case (md.op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                {phi_r, plo_r} <= md_result(md.op, md.A, md.B);
                cnt_r   <= md.op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                state_r <= RUN;
                busy_r  <= 1'b1;
              end
              3'd4:    hi_r <= md.A;
              3'd5:    lo_r <= md.A;
              default: hi_r <= hi_r;
            endcase
          end else begin
            busy_r <= 1'b0;
          end
        end
        RUN: begin
          // Any start seen here is dropped; the hazard unit should never issue one.
          if (cnt_r == CW'(1)) begin
            hi_r    <= phi_r;
            lo_r    <= plo_r;
            cnt_r   <= {CW{1'b0}};
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign md.busy      = busy_r;
  assign md.HI        = hi_r;
  assign md.LO        = lo_r;
  // Combinational so a dependent instruction in Decode stalls in the issue cycle.
  assign md.stall_req = md.md_in_D & (md.start | busy_r);

endmodule

// File: tb/tb_md_ctrl.sv
// Randomized scoreboard bench for md_ctrl: stimulus pushes expected commits,
// a negedge monitor compares HI/LO/busy/stall_req every cycle.
module tb_md_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  md_ctrl_if md ();

  md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          issue;
    int          due;
    bit          is_md;
    logic [31:0] hi;
    logic [31:0] lo;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mh = 32'd0;
  logic [31:0] ml = 32'd0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;
  int          last_due = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Architectural effect of an MD op computed with 64-bit arithmetic.
  function automatic void ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 inout logic [31:0] h, inout logic [31:0] l);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      3'd0: begin sp = sa * sb; h = sp[63:32]; l = sp[31:0]; end
      3'd1: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
      3'd2: begin
        if (b == 32'd0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin sq = sa / sb; sr = sa - sq * sb; h = sr[31:0]; l = sq[31:0]; end
      end
      3'd3: begin
        if (b == 32'd0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin up = ua / ub; h = up[31:0]; up = ua % ub; l = h; h = up[31:0]; l = 32'(ua / ub); end
      end
      3'd4: h = a;
      3'd5: l = a;
      default: ;
    endcase
  endfunction

  // Drive one start for one cycle; called just after a rising edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic d);
    int   s;
    ent_t e;
    md.start = 1'b1; md.op = o; md.A = a; md.B = b; md.md_in_D = d;
    s = cyc + 1;
    if (o <= 3'd5 && s > last_due) begin
      ref_md(o, a, b, mh, ml);
      e.issue = s;
      e.is_md = (o <= 3'd3);
      e.due   = e.is_md ? s + ((o >= 3'd2) ? 10 : 5) : s;
      e.hi    = mh;
      e.lo    = ml;
      q.push_back(e);
      last_due = e.due;
    end
    @(posedge clk); #1;
    md.start = 1'b0;
  endtask

  task automatic wait_done();
    while (cyc < last_due) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] pick(input bit zero_bias);
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return zero_bias ? 32'd0 : 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard monitor: retire due commits, then compare the whole visible state.
  always @(negedge clk) begin : mon
    ent_t e;
    logic eb;
    if (reset) begin
      exp_hi = 32'd0;
      exp_lo = 32'd0;
    end
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      exp_hi = e.hi;
      exp_lo = e.lo;
    end
    eb = (q.size() > 0) && q[0].is_md && (q[0].issue <= cyc);
    chk("hi", md.HI, exp_hi);
    chk("lo", md.LO, exp_lo);
    chk("busy", {31'd0, md.busy}, {31'd0, eb});
    chk("stall_req", {31'd0, md.stall_req}, {31'd0, md.md_in_D & (md.start | eb)});
  end

  initial begin
    logic [2:0] o;
    reset = 1'b1;
    md.start = 1'b0; md.op = 3'd0; md.A = 32'd0; md.B = 32'd0; md.md_in_D = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", md.HI, 32'd0);
    chk("rst_lo", md.LO, 32'd0);
    chk("rst_busy", {31'd0, md.busy}, 32'd0);
    reset = 1'b0;
    last_due = cyc;

    issue(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0); wait_done();
    chk("mult_hi", md.HI, 32'hFFFF_FFFF); chk("mult_lo", md.LO, 32'hFFFF_FFFE);
    issue(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0); wait_done();
    chk("multu_hi", md.HI, 32'h0000_0001); chk("multu_lo", md.LO, 32'hFFFF_FFFE);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1); wait_done();
    md.md_in_D = 1'b0;
    chk("div_hi", md.HI, 32'hFFFF_FFFF); chk("div_lo", md.LO, 32'hFFFF_FFFD);
    issue(3'd3, 32'd7, 32'd0, 1'b0); wait_done();
    chk("divu0_hi", md.HI, 32'd7); chk("divu0_lo", md.LO, 32'hFFFF_FFFF);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0); wait_done();
    chk("divovf_hi", md.HI, 32'd0); chk("divovf_lo", md.LO, 32'h8000_0000);
    issue(3'd4, 32'h1234_5678, 32'd0, 1'b1);
    md.md_in_D = 1'b0;
    chk("mthi_hi", md.HI, 32'h1234_5678);
    issue(3'd5, 32'hCAFE_BABE, 32'd0, 1'b0);
    chk("mtlo_lo", md.LO, 32'hCAFE_BABE); chk("mtlo_hi", md.HI, 32'h1234_5678);

    // Second start while busy must be dropped.
    issue(3'd0, 32'd3, 32'd4, 1'b0);
    issue(3'd2, 32'd100, 32'd7, 1'b0);
    wait_done();
    chk("ign_hi", md.HI, 32'd0); chk("ign_lo", md.LO, 32'd12);
    issue(3'd4, 32'hDEAD_BEEF, 32'd0, 1'b0);

    // Reset in the third cycle of a divide.
    issue(3'd2, 32'd1000, 32'd3, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    q.delete();
    mh = 32'd0; ml = 32'd0;
    last_due = cyc;
    #1;
    chk("mid_rst_busy", {31'd0, md.busy}, 32'd0);
    chk("mid_rst_hi", md.HI, 32'd0);
    chk("mid_rst_lo", md.LO, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    md.md_in_D = 1'b0;
    last_due = cyc;
    issue(3'd0, 32'd6, 32'd7, 1'b0); wait_done();
    chk("post_rst_lo", md.LO, 32'd42); chk("post_rst_hi", md.HI, 32'd0);

    for (int i = 0; i < 300; i++) begin
      o = 3'($urandom_range(0, 7));
      issue(o, pick(1'b0), pick(1'b1), 1'($urandom_range(0, 1)));
      md.md_in_D = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 12)) @(posedge clk);
      #1;
    end
    wait_done();
    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
